// File: rtl/key_debounce_if.sv
// Key-conditioner signal bundle: raw key levels in, debounced levels and edge pulses out.
interface key_debounce_if #(
  parameter int N_KEYS = 12
);
  logic [N_KEYS-1:0] keys_raw;
  logic [N_KEYS-1:0] keys_clean;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic              any_key;

  modport master (output keys_raw, input keys_clean, key_press, key_release, any_key);
  modport slave  (input keys_raw, output keys_clean, key_press, key_release, any_key);
endinterface

// File: rtl/key_debounce.sv
// Per-key debouncer: two-flop synchroniser feeding independent stability counters,
// producing clean levels, one-cycle press/release pulses and an any-key flag.
module key_debounce_lane #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rstn,
  input  logic sync_i,
  output logic clean_o,
  output logic press_o,
  output logic release_o,
  output logic clean_nxt_o
);
  typedef enum logic {STABLE, PENDING} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Any return to the clean value drops back to STABLE and clears the count.
  always_comb begin
    state     = (sync_i != clean_q) ? PENDING : STABLE;
    cnt_d     = '0;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state)
      PENDING: begin
        if (cnt_q == LAST) begin
          clean_d   = sync_i;
          press_d   = sync_i;
          release_d = ~sync_i;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign clean_o     = clean_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign clean_nxt_o = clean_d;
endmodule

module key_debounce #(
  parameter int N_KEYS          = 12,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         rstn,
  key_debounce_if.slave kb
);
  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic              any_key_q, any_key_d;
  logic [N_KEYS-1:0] clean, press, rel, clean_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      any_key_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      any_key_q <= any_key_d;
    end
  end

  always_comb begin
    sync1_d   = kb.keys_raw;
    sync2_d   = sync1_q;
    any_key_d = |clean_nxt;
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk        (clk),
      .rstn       (rstn),
      .sync_i     (sync2_q[i]),
      .clean_o    (clean[i]),
      .press_o    (press[i]),
      .release_o  (rel[i]),
      .clean_nxt_o(clean_nxt[i])
    );
  end

  assign kb.keys_clean  = clean;
  assign kb.key_press   = press;
  assign kb.key_release = rel;
  assign kb.any_key     = any_key_q;
endmodule
